// File: rtl/aes_iter_cipher.sv
// aes_iter_cipher: iterative AES-128/192/256 block cipher, one round per clock.
// Define AES_DECRYPT_EN to add the in_decrypt port and the inverse round datapath.
module aes_iter_cipher #(
  parameter  int NK = 4,
  localparam int NR = NK + 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
`ifdef AES_DECRYPT_EN
  input  logic                  in_decrypt,
`endif
  input  logic [0:127]          in_data,
  input  logic [0:128*(NR+1)-1] key_schedule,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:127]          out_data,
  output logic                  busy
);
  localparam int CW = $clog2(NR + 1);
  localparam logic [CW-1:0] NR_C = CW'(NR);

  typedef logic [0:15][7:0] blk_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_iter_cipher: NK must be 4, 6 or 8");
  end

  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; maps 0 to 0 as AES requires
  function automatic logic [7:0] ginv(logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(logic [7:0] a, int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] a);
    logic [7:0] y;
    y = ginv(a);
    return y ^ rl(y, 1) ^ rl(y, 2) ^ rl(y, 3) ^ rl(y, 4) ^ 8'h63;
  endfunction

  function automatic blk_t sub_bytes(blk_t s);
    blk_t o;
    for (int i = 0; i < 16; i++) o[i] = sbox(s[i]);
    return o;
  endfunction

  function automatic blk_t shift_rows(blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = s[4*((c+r)%4)+r];
    return o;
  endfunction

  function automatic blk_t mix_columns(blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = gmul(s[4*c+r], 8'h02) ^ gmul(s[4*c+(r+1)%4], 8'h03)
                 ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
    return o;
  endfunction

`ifdef AES_DECRYPT_EN
  function automatic logic [7:0] inv_sbox(logic [7:0] s);
    return ginv(rl(s, 1) ^ rl(s, 3) ^ rl(s, 6) ^ 8'h05);
  endfunction

  function automatic blk_t inv_sub_bytes(blk_t s);
    blk_t o;
    for (int i = 0; i < 16; i++) o[i] = inv_sbox(s[i]);
    return o;
  endfunction

  function automatic blk_t inv_shift_rows(blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = s[4*((c-r+4)%4)+r];
    return o;
  endfunction

  function automatic blk_t inv_mix_columns(blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = gmul(s[4*c+r], 8'h0e) ^ gmul(s[4*c+(r+1)%4], 8'h0b)
                 ^ gmul(s[4*c+(r+2)%4], 8'h0d) ^ gmul(s[4*c+(r+3)%4], 8'h09);
    return o;
  endfunction
`endif

  state_t        state;
  state_t        nstate;
  logic [CW-1:0] ctr;
  blk_t          st;
  blk_t          rk;
  blk_t          t;
  blk_t          nxt;
  logic          last;
  logic          acc;
  logic [0:127]  rk_fst;

`ifdef AES_DECRYPT_EN
  logic          dec;
  logic [0:127]  rk_lst;
  assign rk_lst = key_schedule[128*NR +: 128];
`else
  localparam logic dec = 1'b0;
`endif

  assign rk_fst = key_schedule[0 +: 128];
  assign acc    = in_valid & in_ready;

  always_comb begin
    rk   = key_schedule[128*int'(ctr) +: 128];
    t    = shift_rows(sub_bytes(st));
    last = (ctr == NR_C);
    nxt  = (last ? t : mix_columns(t)) ^ rk;
`ifdef AES_DECRYPT_EN
    if (dec) begin
      t    = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
      last = (ctr == '0);
      nxt  = last ? t : inv_mix_columns(t);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (in_valid) nstate = RUN;
      RUN:     if (last) nstate = DONE;
      DONE:    if (out_ready) nstate = in_valid ? RUN : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      RUN:     busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= '0;
      ctr      <= '0;
      out_data <= '0;
`ifdef AES_DECRYPT_EN
      dec      <= 1'b0;
`endif
    end else if (acc) begin
`ifdef AES_DECRYPT_EN
      dec <= in_decrypt;
      st  <= in_data ^ (in_decrypt ? rk_lst : rk_fst);
      ctr <= in_decrypt ? NR_C - 1'b1 : CW'(1);
`else
      st  <= in_data ^ rk_fst;
      ctr <= CW'(1);
`endif
    end else if (state == RUN) begin
      st  <= nxt;
      ctr <= last ? '0 : (dec ? ctr - 1'b1 : ctr + 1'b1);
      if (last) out_data <= nxt;
    end
  end
endmodule
